serial_adder_unit: RTL and testbench
====================================

Name: serial_adder_unit

Overview:
- Bit-serial N-bit adder built around a single full-adder cell.
- Operands load into shift registers. One sum bit is produced per clock, LSB first, with the carry held in a flip-flop between bits.
- Sits directly downstream of the full-adder cell. It consumes that cell's sum and carry_out each cycle and feeds the carry back as the cell's z input.
- Used where area matters more than latency, and as the sequential exercise built on the combinational adder.

Parameters:
- N, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin an addition; sampled on rising clk.
- a  input  N  operand A; captured when start is accepted.
- b  input  N  operand B; captured when start is accepted.
- cin  input  1  carry-in; captured when start is accepted.
- busy  output  1  high while bits are being shifted.
- done  output  1  single-cycle pulse; result registers just updated.
- sum  output  N  registered result of the last completed addition.
- cout  output  1  registered carry-out of the last completed addition.

Behaviour:
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
- While rst_n=0:
  - state=IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry flop and bit counter are all 0.
  - Takes effect immediately, without waiting for clk. Deassertion is sampled on clk.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - If start=1 at an edge: load a_sr<=a, b_sr<=b, carry<=cin, cnt<=0, then go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - busy=1.
  - Each edge evaluates full-add of a_sr[0], b_sr[0] and carry.
  - The sum bit shifts into acc MSB (acc shifts right). a_sr and b_sr shift right. carry<=carry_out. cnt<=cnt+1.
  - At the edge where cnt==N-1 (the Nth bit): sum<=final acc value (including this bit), cout<=carry_out of this bit, then go to DONE.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - If start=1 at this edge, accept a new operation exactly as from IDLE and go to SHIFT (back-to-back allowed). Otherwise go to IDLE.
- Latency:
  - Start accepted at edge E0.
  - done is high in the cycle after edge E0+N.
  - sum/cout are valid from that same cycle.
- Throughput: one addition per N+1 cycles.
- start while busy=1 is ignored. Operands and cin are not re-captured.
- a, b and cin are don't-care except at the accepting edge.
- sum/cout hold their value until the next completion or reset. They never show partial results mid-shift.
- Arithmetic: {cout,sum} = a + b + cin, exact, no truncation beyond N+1 bits.
- Reset mid-SHIFT: the operation is aborted and all outputs go to 0. No done pulse is produced for the aborted operation.
- Counter width: clog2(N) bits, sufficient to reach N-1. No wrap occurs inside an operation.

Test Plan:
- Reset then a=8'h00, b=8'h00, cin=0, start pulse:
  - busy high for 8 cycles.
  - done pulses 8 cycles after the accept edge.
  - sum=8'h00, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1 (full carry ripple through all bits).
- a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1. Then start held high during busy with a=8'h01, b=8'h01: ignored, result still 8'h00/1.
- Back-to-back operations:
  - First: 8'h12+8'h34 with cin=0, giving done with sum=8'h46, cout=0.
  - start asserted in the done cycle with 8'h80+8'h80 -> second done exactly 9 cycles after the first, sum=8'h00, cout=1.
- Reset mid-op:
  - Start 8'h0F+8'h01.
  - Drop rst_n for 1 cycle after 3 SHIFT edges -> sum=0, cout=0, busy=0 immediately, and no done pulse.
  - Then 8'h0F+8'h01 completes as 8'h10, cout=0.
- N=4 instance:
  - 4'hF+4'hF with cin=1 -> sum=4'hF, cout=1, done 4 cycles after accept.
  - Compare all 512 a/b/cin combinations against a+b+cin.

Source files
------------

// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder: start request, operands and registered result.
interface serial_adder_if #(
  parameter int unsigned N = 8
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_unit.sv
// Bit-serial N-bit adder: one full-add per clock, LSB first, carry held in a flop between bits.
module serial_adder_unit #(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     a_sr_q, a_sr_d;
  logic [N-1:0]     b_sr_q, b_sr_d;
  logic [N-1:0]     acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [N-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             fa_sum_c;
  logic             fa_cout_c;

  // Full-adder cell on the current LSBs with the carry fed back as its third input.
  always_comb begin
    fa_sum_c  = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    fa_cout_c = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
  end

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        acc_d   = {fa_sum_c, acc_q[N-1:1]};
        carry_d = fa_cout_c;
        cnt_d   = cnt_q + CNT_W'(1);
        // Last bit: publish the completed word so sum never shows partial results.
        if (cnt_q == CNT_W'(N - 1)) begin
          sum_d   = {fa_sum_c, acc_q[N-1:1]};
          cout_d  = fa_cout_c;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder_unit.sv
// Directed bench for serial_adder_unit at N=8 and N=4 with hand-computed results.
module tb_serial_adder_unit;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  serial_adder_if #(.N(8)) bus8 ();
  serial_adder_if #(.N(4)) bus4 ();

  serial_adder_unit #(.N(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_adder_unit #(.N(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one edge; returns sampling the cycle after the accept edge.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
  endtask

  // Waits for done, counting cycles since accept and cycles with busy high; optionally holds start with junk operands while busy.
  task automatic wait8(input bit hold, output int cyc, output int busyc);
    cyc = 0; busyc = 0;
    while (!bus8.done && cyc < 40) begin
      if (bus8.busy) busyc++;
      if (hold) begin
        bus8.start = bus8.busy; bus8.a = 8'h01; bus8.b = 8'h01; bus8.cin = 1'b0;
      end
      step();
      cyc++;
    end
    bus8.start = 1'b0;
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input logic [7:0] es, input logic ec, input bit hold);
    int cyc, busyc;
    issue8(a, b, cin);
    wait8(hold, cyc, busyc);
    check({tag, "_lat"}, cyc, 8);
    check({tag, "_busycyc"}, busyc, 8);
    check({tag, "_busy_at_done"}, bus8.busy, 0);
    check({tag, "_sum"}, bus8.sum, es);
    check({tag, "_cout"}, bus8.cout, ec);
  endtask

  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    bus4.a = a; bus4.b = b; bus4.cin = cin; bus4.start = 1'b1;
    step();
    bus4.start = 1'b0;
  endtask

  task automatic wait4(output int cyc);
    cyc = 0;
    while (!bus4.done && cyc < 40) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    int cyc, busyc, pulses;
    n_tests = 0; n_fail = 0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_busy", bus8.busy, 0);
    check("rst_done", bus8.done, 0);
    check("rst_sum", bus8.sum, 0);
    check("rst_cout", bus8.cout, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    run8("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    check("done_one_cycle", bus8.done, 0);

    run8("ripple", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    step();
    run8("a5_5a_hold", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b1);
    step();
    check("hold_no_restart", bus8.busy, 0);

    // Back-to-back: second op accepted on the edge right after the first done cycle.
    run8("b2b_first", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    issue8(8'h80, 8'h80, 1'b0);
    wait8(1'b0, cyc, busyc);
    check("b2b_gap", cyc + 1, 9);
    check("b2b_sum", bus8.sum, 8'h00);
    check("b2b_cout", bus8.cout, 1);

    // Reset after three shift edges aborts the operation.
    step();
    issue8(8'h0F, 8'h01, 1'b0);
    step(); step(); step();
    check("midrst_busy_before", bus8.busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", bus8.busy, 0);
    check("midrst_sum", bus8.sum, 0);
    check("midrst_cout", bus8.cout, 0);
    step();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus8.done) pulses++;
      step();
    end
    check("midrst_no_done", pulses, 0);
    run8("after_rst", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);

    // N=4 instance.
    step();
    issue4(4'hF, 4'hF, 1'b1);
    wait4(cyc);
    check("n4_lat", cyc, 4);
    check("n4_sum", bus4.sum, 4'hF);
    check("n4_cout", bus4.cout, 1);
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          step();
          issue4(4'(a), 4'(b), 1'(c));
          wait4(cyc);
          check($sformatf("n4_%0h_%0h_%0d", a, b, c), {27'd0, bus4.cout, bus4.sum}, 32'(a + b + c));
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
